// File: rtl/stopwatch_ctrl.sv
// Run/lap/pause controller: divides clk into count ticks, gates them to the counter chain, drives clear/hold.
// Optional auto-stop at chain maximum is enabled by defining STOPWATCH_AUTO_STOP_EN.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV  = 100000,
  parameter int unsigned DIV_WIDTH = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  input  logic       wrap,
  output logic       count_en,
  output logic       count_clr,
  output logic       hold,
  output logic       running,
  output logic [1:0] state
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_LAP   = 2'b10;
  localparam logic [1:0] S_PAUSE = 2'b11;

  localparam logic [DIV_WIDTH-1:0] TERM = DIV_WIDTH'(TICK_DIV - 1);

  logic [1:0]           state_next;
  logic [DIV_WIDTH-1:0] presc;
  logic [DIV_WIDTH-1:0] presc_next;
  logic                 count_en_next;
  logic                 count_clr_next;
  logic                 active;
  logic                 terminal;
  logic                 auto_stop;
  logic                 resume_ok;

  assign active   = (state == S_RUN) || (state == S_LAP);
  assign terminal = active && (presc == TERM);

`ifdef STOPWATCH_AUTO_STOP_EN
  // At maximum the tick that would roll the chain over is swallowed and the watch parks in PAUSE.
  assign auto_stop = terminal && wrap;
  assign resume_ok = !wrap;
`else
  logic unused_wrap;
  assign unused_wrap = wrap;
  assign auto_stop   = 1'b0;
  assign resume_ok   = 1'b1;
`endif

  // Next-state, prescaler and registered-output decode.
  always_comb begin
    state_next     = state;
    presc_next     = presc;
    count_en_next  = 1'b0;
    count_clr_next = 1'b0;

    case (state)
      S_IDLE: begin
        if (clear) begin
          count_clr_next = 1'b1;
        end else if (start_stop) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (start_stop) begin
          state_next = S_PAUSE;
        end else if (lap) begin
          state_next = S_LAP;
        end
      end
      S_LAP: begin
        if (start_stop) begin
          state_next = S_PAUSE;
        end else if (lap) begin
          state_next = S_RUN;
        end
      end
      default: begin
        if (clear) begin
          state_next     = S_IDLE;
          count_clr_next = 1'b1;
        end else if (start_stop && resume_ok) begin
          state_next = S_RUN;
        end
      end
    endcase

    if (auto_stop) begin
      state_next = S_PAUSE;
    end

    count_en_next = terminal && !auto_stop;

    // Prescaler runs in RUN/LAP, holds in PAUSE so the partial tick survives a pause.
    if (active) begin
      presc_next = terminal ? '0 : presc + DIV_WIDTH'(1);
    end
    if (state_next == S_IDLE) begin
      presc_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      presc     <= '0;
      count_en  <= 1'b0;
      count_clr <= 1'b0;
      hold      <= 1'b0;
      running   <= 1'b0;
    end else begin
      state     <= state_next;
      presc     <= presc_next;
      count_en  <= count_en_next;
      count_clr <= count_clr_next;
      hold      <= (state_next == S_LAP);
      running   <= (state_next == S_RUN) || (state_next == S_LAP);
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4; expectations are hand-derived cycle by cycle.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_stop = 1'b0;
  logic       lap = 1'b0;
  logic       clear = 1'b0;
  logic       wrap = 1'b0;
  logic       count_en;
  logic       count_clr;
  logic       hold;
  logic       running;
  logic [1:0] state;

  int checks = 0;
  int passes = 0;

  stopwatch_ctrl #(.TICK_DIV(4), .DIV_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .start_stop(start_stop), .lap(lap), .clear(clear), .wrap(wrap),
    .count_en(count_en), .count_clr(count_clr), .hold(hold), .running(running), .state(state)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic s, input logic l, input logic c);
    start_stop = s; lap = l; clear = c;
    step();
    start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
  endtask

  task automatic apply_reset();
    wrap = 1'b0;
    rst  = 1'b0;
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    checks++; if ({state, count_en, count_clr, hold, running} !== 6'b0) $display("FAIL reset_outputs: got %b want 000000", {state, count_en, count_clr, hold, running}); else passes++;
    step();
    rst = 1'b1;
    step();
    checks++; if (state !== 2'b00) $display("FAIL reset_idle: got %b want 00", state); else passes++;
  endtask

  task automatic test_run();
    apply_reset();
    pulse(1'b1, 1'b0, 1'b0);
    checks++; if (state !== 2'b01) $display("FAIL run_state: got %b want 01", state); else passes++;
    checks++; if (running !== 1'b1) $display("FAIL run_running: got %b want 1", running); else passes++;
    for (int p = 0; p < 3; p++) begin
      int early = 0;
      for (int i = 0; i < 3; i++) begin
        step();
        if (count_en !== 1'b0) early++;
      end
      checks++; if (early !== 0) $display("FAIL run_gap%0d: got %0d early ticks want 0", p, early); else passes++;
      step();
      checks++; if (count_en !== 1'b1) $display("FAIL run_tick%0d: got %b want 1", p, count_en); else passes++;
    end
  endtask

  task automatic test_pause_resume();
    int bad = 0;
    apply_reset();
    pulse(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step();
    checks++; if (count_en !== 1'b1) $display("FAIL pr_first_tick: got %b want 1", count_en); else passes++;
    step();
    pulse(1'b1, 1'b0, 1'b0);
    checks++; if (state !== 2'b11) $display("FAIL pr_pause_state: got %b want 11", state); else passes++;
    checks++; if (running !== 1'b0) $display("FAIL pr_pause_running: got %b want 0", running); else passes++;
    for (int i = 0; i < 20; i++) begin
      step();
      if (count_en !== 1'b0 || state !== 2'b11) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL pr_pause_quiet: got %0d bad cycles want 0", bad); else passes++;
    pulse(1'b1, 1'b0, 1'b0);
    checks++; if (state !== 2'b01) $display("FAIL pr_resume_state: got %b want 01", state); else passes++;
    step();
    checks++; if (count_en !== 1'b0) $display("FAIL pr_resume_early: got %b want 0", count_en); else passes++;
    step();
    checks++; if (count_en !== 1'b1) $display("FAIL pr_resume_tick: got %b want 1", count_en); else passes++;
  endtask

  task automatic test_lap();
    int early = 0;
    apply_reset();
    pulse(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step();
    pulse(1'b0, 1'b1, 1'b0);
    checks++; if (state !== 2'b10) $display("FAIL lap_state: got %b want 10", state); else passes++;
    checks++; if (hold !== 1'b1) $display("FAIL lap_hold: got %b want 1", hold); else passes++;
    checks++; if (count_en !== 1'b1) $display("FAIL lap_entry_tick: got %b want 1", count_en); else passes++;
    for (int i = 0; i < 3; i++) begin
      step();
      if (count_en !== 1'b0) early++;
    end
    step();
    checks++; if (early !== 0 || count_en !== 1'b1) $display("FAIL lap_tick: got early=%0d en=%b want early=0 en=1", early, count_en); else passes++;
    pulse(1'b0, 1'b1, 1'b0);
    checks++; if ({state, hold, running} !== 4'b0101) $display("FAIL lap_release: got %b want 0101", {state, hold, running}); else passes++;
    step();
    step();
    checks++; if (count_en !== 1'b0) $display("FAIL lap_release_early: got %b want 0", count_en); else passes++;
    step();
    checks++; if (count_en !== 1'b1) $display("FAIL lap_release_tick: got %b want 1", count_en); else passes++;
  endtask

  task automatic test_clear_priority();
    int early = 0;
    apply_reset();
    pulse(1'b0, 1'b0, 1'b1);
    checks++; if ({state, count_clr} !== 3'b001) $display("FAIL clr_idle: got %b want 001", {state, count_clr}); else passes++;
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    checks++; if ({state, count_clr} !== 3'b010) $display("FAIL clr_ignored_run: got %b want 010", {state, count_clr}); else passes++;
    pulse(1'b1, 1'b1, 1'b0);
    checks++; if (state !== 2'b11) $display("FAIL ss_beats_lap: got %b want 11", state); else passes++;
    pulse(1'b1, 1'b1, 1'b1);
    checks++; if ({state, count_clr, running, hold} !== 5'b00100) $display("FAIL clr_wins: got %b want 00100", {state, count_clr, running, hold}); else passes++;
    step();
    checks++; if ({state, count_clr} !== 3'b000) $display("FAIL clr_one_cycle: got %b want 000", {state, count_clr}); else passes++;
    pulse(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      if (count_en !== 1'b0) early++;
    end
    step();
    checks++; if (early !== 0 || count_en !== 1'b1) $display("FAIL clr_presc_zero: got early=%0d en=%b want early=0 en=1", early, count_en); else passes++;
  endtask

  task automatic test_reset_midrun();
    int bad = 0;
    apply_reset();
    pulse(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step();
    checks++; if (count_en !== 1'b1) $display("FAIL rm_pre_tick: got %b want 1", count_en); else passes++;
    rst = 1'b0;
    #1;
    checks++; if ({state, count_en, count_clr, hold, running} !== 6'b0) $display("FAIL rm_async: got %b want 000000", {state, count_en, count_clr, hold, running}); else passes++;
    step();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (count_en !== 1'b0 || state !== 2'b00) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL rm_after_release: got %0d bad cycles want 0", bad); else passes++;
  endtask

  task automatic test_wrap();
    apply_reset();
    pulse(1'b1, 1'b0, 1'b0);
    step();
    step();
    pulse(1'b0, 1'b1, 1'b0);
    wrap = 1'b1;
    step();
`ifdef STOPWATCH_AUTO_STOP_EN
    checks++; if ({count_en, state, hold, running} !== 5'b01100) $display("FAIL wrap_autostop: got %b want 01100", {count_en, state, hold, running}); else passes++;
    pulse(1'b1, 1'b0, 1'b0);
    checks++; if (state !== 2'b11) $display("FAIL wrap_ss_ignored: got %b want 11", state); else passes++;
`else
    checks++; if ({count_en, state, hold, running} !== 5'b11011) $display("FAIL wrap_rollover: got %b want 11011", {count_en, state, hold, running}); else passes++;
    pulse(1'b1, 1'b0, 1'b0);
    checks++; if (state !== 2'b11) $display("FAIL wrap_pause: got %b want 11", state); else passes++;
`endif
    pulse(1'b0, 1'b0, 1'b1);
    checks++; if ({state, count_clr} !== 3'b001) $display("FAIL wrap_clear: got %b want 001", {state, count_clr}); else passes++;
    wrap = 1'b0;
  endtask

  initial begin
    test_reset();
    test_run();
    test_pause_resume();
    test_lap();
    test_clear_priority();
    test_reset_midrun();
    test_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Run/lap/pause controller for the stopwatch counter chain. It divides the system clock into a base tick, gates that tick onto the enable input of the first counter stage, issues a synchronous clear to the whole chain, and drives the display-hold (lap) signal. Inputs come from the debounced, single-cycle-pulse button front end. Outputs feed the counter chain and the seven-segment display mux.

## Interface
- `TICK_DIV`, default 100000: clk cycles per count tick (100 MHz to 1 ms); legal range ≥ 2.
- `DIV_WIDTH`, default 17: prescaler width; must satisfy 2^DIV_WIDTH ≥ TICK_DIV.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start_stop`  in  1  one-cycle pulse: toggles run/pause.
- `lap`  in  1  one-cycle pulse: freezes or releases the displayed value.
- `clear`  in  1  one-cycle pulse: zeroes the time.
- `wrap`  in  1  high when every counter stage sits at its threshold (chain at maximum value).
- `count_en`  out  1  one-cycle tick to the counter chain enable.
- `count_clr`  out  1  one-cycle synchronous clear to the counter chain.
- `hold`  out  1  display latch hold (high in LAP).
- `running`  out  1  high in RUN or LAP.
- `state`  out  2  IDLE=00, RUN=01, LAP=10, PAUSE=11.

## Operation
- All outputs are registered. Reset values: `state`=IDLE, and `count_en`, `count_clr`, `hold`, `running` and the prescaler are all 0. Reset takes effect immediately on `rst` low, including mid-count. The counter chain is not cleared by this block on reset; it has its own reset.
- FSM transitions (anything not listed holds state):
  - IDLE: `start_stop` goes to RUN.
  - RUN: `start_stop` goes to PAUSE; `lap` goes to LAP.
  - LAP: `lap` goes to RUN; `start_stop` goes to PAUSE.
  - PAUSE: `start_stop` goes to RUN; `clear` goes to IDLE.
- `clear` is ignored in RUN and LAP. In IDLE, `clear` re-issues `count_clr` and the state stays IDLE.
- Simultaneous pulses: priority is `clear` > `start_stop` > `lap`. Only the winner is acted on and the others are dropped.
- Prescaler behaviour:
  - Counts only in RUN or LAP and wraps from TICK_DIV-1 to 0.
  - Holds its value in PAUSE, so the residual fraction is kept on resume.
  - Is forced to 0 on entry to IDLE.
- `count_en` is asserted for exactly one cycle after each prescaler terminal count (state RUN or LAP with prescaler = TICK_DIV-1).
  - A terminal count in the same cycle that `start_stop` is sampled still produces its tick.
- `count_clr` is asserted for exactly one cycle after any accepted `clear`.
- `hold` = (state == LAP). `running` = (state is RUN or LAP).

## Timing
- Input to output latency: a pulse sampled at edge N changes `state`, `hold` and `running` after edge N; `count_clr` also rises after edge N.
- First `count_en` comes TICK_DIV cycles after `state` first shows RUN. After that, ticks are exactly TICK_DIV cycles apart while running.
- After PAUSE then RUN, the next tick arrives (TICK_DIV − prescaler value at pause) cycles after RUN resumes.
- `count_en` and `count_clr` are never high in the same cycle. `clear` is accepted only in IDLE or PAUSE, where no ticks are produced.
- LAP does not alter tick timing. Ticks continue undisturbed through LAP entry and exit.

## Configuration
- Macro: `STOPWATCH_AUTO_STOP_EN`.
- When defined, auto-stop at maximum is compiled in. In RUN or LAP, if `wrap`=1 at a prescaler terminal count:
  - that tick is suppressed (`count_en` stays 0);
  - the FSM goes to PAUSE;
  - `hold` drops, so the display shows the maximum value.
  - While `wrap`=1, `start_stop` from PAUSE is ignored; only `clear` leaves PAUSE.
- When not defined: `wrap` is unused and ticks continue, so the counter chain rolls over to 0.

## Test plan
All scenarios use TICK_DIV=4.
- Reset, then `start_stop`: RUN after 1 edge; `count_en` pulses 4 cycles later, then every 4 cycles; `running`=1.
- Run 6 cycles, `start_stop`, wait 20, `start_stop`: no ticks during PAUSE; first tick 2 cycles after resume.
- RUN, `lap`, then `lap`: `hold`=1 in between, ticks continue every 4 cycles, and `state` goes 10 then 01.
- PAUSE with `clear`, `start_stop` and `lap` in the same cycle: `clear` wins; state becomes IDLE, one-cycle `count_clr`, prescaler 0.
- `rst` low in the middle of a RUN tick: all outputs 0 immediately; after release, state is IDLE and no `count_en`.
- With `STOPWATCH_AUTO_STOP_EN` defined, `wrap`=1 at a terminal count: no `count_en`, state becomes PAUSE, and `start_stop` is ignored until `clear`. With the macro undefined, the same stimulus produces the tick.
